mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AddrWidth, default 32, byte-address width of both requester ports.
REQ-002 Parameter MemDepth, default 16384, RAM depth in 32-bit words; word index = addr[AddrWidth-1:2].
REQ-003 Parameter StarveLimit, default 4, consecutive denied instruction-request cycles before instruction priority is forced.
REQ-004 clk_i  input  1  system clock; all state updates on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-006 instr_req_i / instr_addr_i  input  1 / AddrWidth  instruction-fetch request and byte address; read-only.
REQ-007 instr_gnt_o / instr_rvalid_o / instr_err_o / instr_rdata_o  output  1 / 1 / 1 / 32  grant, response valid, error, read data.
REQ-008 data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i  input  1 / 1 / 4 / AddrWidth / 32  load-store request.
REQ-009 data_gnt_o / data_rvalid_o / data_err_o / data_rdata_o  output  1 / 1 / 1 / 32  grant, response valid, error, read data.
REQ-010 ram_req_o / ram_we_o / ram_be_o / ram_addr_o / ram_wdata_o  output  1 / 1 / 4 / log2(MemDepth) / 32  single-port RAM command.
REQ-011 ram_rdata_i  input  32  RAM read data, valid the cycle after ram_req_o.

Function
REQ-012 At most one gnt SHALL be high per cycle; gnt is combinational from req and arbitration state; a granted request is accepted that cycle.
REQ-013 Arbitration: data wins when both request, except when starve counter equals StarveLimit, then instruction wins.
REQ-014 Starve counter SHALL increment each cycle instr_req_i is high and not granted, saturate at StarveLimit, and clear on any instruction grant or when instr_req_i is low.
REQ-015 Granted in-range request SHALL drive ram_req_o=1 with the requester's address index, we, be, wdata the same cycle; instruction grants force ram_we_o=0, ram_be_o=4'hF.
REQ-016 Response SHALL be exactly one cycle after grant: owner's rvalid=1 for one cycle, for reads and writes; writes return rdata=0.
REQ-017 Back-to-back grants every cycle SHALL be supported; a response and a new grant in the same cycle are independent.
REQ-018 Word index >= MemDepth: grant given, ram_req_o=0, response next cycle with err=1, rdata=0.
REQ-019 rdata_o and err_o SHALL be 0 whenever the corresponding rvalid_o is 0.
REQ-020 Non-owner response outputs SHALL stay 0 during a response cycle.

Reset
REQ-021 Asserting rstn_i low SHALL asynchronously clear response-valid, response-owner, response-error and starve-counter state; all gnt, rvalid, err, rdata and ram_req_o outputs read 0 while reset is low.
REQ-022 A request granted in the cycle reset asserts SHALL produce no response; first grant possible in the first cycle after rstn_i rises.

Configuration
REQ-023 Macro MEM_ARBITER_RR_EN defined: REQ-013/REQ-014 replaced by round-robin — on simultaneous requests, the port not granted most recently wins; last-granted flag resets to instruction, so data wins the first tie.
REQ-024 MEM_ARBITER_RR_EN undefined: fixed data priority with starvation guard per REQ-013/REQ-014; no round-robin state exists.

Structure
REQ-025 Package mem_arbiter_pkg SHALL hold the owner enum (OWNER_NONE, OWNER_INSTR, OWNER_DATA) and default StarveLimit constant.
REQ-026 Arbitration decision (priority/round-robin plus starve counter) SHALL live in one sub-module mem_arb_sel; datapath muxing and response routing stay in mem_arbiter.

Verification
REQ-027 Instr only: read 0x80, RAM word 32 = 0x00000013 -> instr_gnt same cycle, next cycle instr_rvalid=1, rdata=0x00000013, err=0.
REQ-028 Data store then load: write 0x12345678 be=4'hF at 0x1000, load 0x1000 next cycle -> ram_addr_o=1024 both, load rdata=0x12345678, store response rdata=0.
REQ-029 Both request continuously (fixed priority, StarveLimit=4) -> data granted 4 cycles, instruction granted on 5th, pattern repeats; never two gnt high.
REQ-030 Same stimulus with MEM_ARBITER_RR_EN -> grants alternate data, instr, data, ...
REQ-031 Data load at word index MemDepth (0x10000 for default) -> gnt, ram_req_o=0, next cycle data_rvalid=1, err=1, rdata=0.
REQ-032 Reset asserted in the cycle after a grant -> no rvalid, all outputs 0 during reset, normal grant first cycle after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   owner_e              : which requester owns the pending response
//   rsp_t                : registered response bookkeeping
//   STARVE_LIMIT_DEFAULT : default instruction starvation guard
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

  typedef struct packed {
    owner_e owner;  // OWNER_NONE means no response this cycle
    logic   err;    // out-of-range access
    logic   we;     // write: response carries zero data
  } rsp_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Arbitration decision between the instruction and data ports.
// Default: data priority with an instruction starvation guard.
// With MEM_ARBITER_RR_EN defined: round-robin on simultaneous requests.
// Ports:
//   clk_i, rstn_i           : clock, async active-low reset
//   instr_req_i, data_req_i : requests
//   instr_gnt_c, data_gnt_c : combinational one-hot grants (0 in reset)
module mem_arb_sel
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned StarveLimit = STARVE_LIMIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_gnt_c,
  output logic data_gnt_c
);

  logic instr_wins;

`ifdef MEM_ARBITER_RR_EN
  // Remembers whether the most recent grant went to the instruction port.
  logic last_instr_q;

  always_comb begin
    instr_wins = !data_req_i || !last_instr_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_instr_q <= 1'b1;
    end else if (instr_gnt_c || data_gnt_c) begin
      last_instr_q <= instr_gnt_c;
    end
  end
`else
  localparam int unsigned CntW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);

  logic [CntW-1:0] starve_q;
  logic [CntW-1:0] starve_d;
  logic            starved;

  always_comb begin
    starved    = (starve_q == CntW'(StarveLimit));
    instr_wins = !data_req_i || starved;
  end

  // Count denied instruction cycles, saturating; clear on grant or idle.
  always_comb begin
    starve_d = '0;
    if (instr_req_i && !instr_gnt_c) begin
      starve_d = starved ? starve_q : starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grants are suppressed while reset is asserted.
  always_comb begin
    instr_gnt_c = rstn_i && instr_req_i && instr_wins;
    data_gnt_c  = rstn_i && data_req_i && !instr_gnt_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch, load/store) arbiter in front of a
// single-port 32-bit RAM with one-cycle read latency.
// Config macro: MEM_ARBITER_RR_EN selects round-robin arbitration.
// Ports:
//   clk_i, rstn_i                       : clock, async active-low reset
//   instr_req_i/addr_i                  : read-only fetch request
//   instr_gnt_o/rvalid_o/err_o/rdata_o  : fetch grant and response
//   data_req_i/we_i/be_i/addr_i/wdata_i : load/store request
//   data_gnt_o/rvalid_o/err_o/rdata_o   : load/store grant and response
//   ram_req_o/we_o/be_o/addr_o/wdata_o  : RAM command
//   ram_rdata_i                         : RAM read data (cycle after req)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned MemDepth    = 16384,
  parameter int unsigned StarveLimit = STARVE_LIMIT_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        instr_req_i,
  input  logic [AddrWidth-1:0]        instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic                        instr_err_o,
  output logic [31:0]                 instr_rdata_o,
  input  logic                        data_req_i,
  input  logic                        data_we_i,
  input  logic [3:0]                  data_be_i,
  input  logic [AddrWidth-1:0]        data_addr_i,
  input  logic [31:0]                 data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic                        data_err_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        ram_req_o,
  output logic                        ram_we_o,
  output logic [3:0]                  ram_be_o,
  output logic [$clog2(MemDepth)-1:0] ram_addr_o,
  output logic [31:0]                 ram_wdata_o,
  input  logic [31:0]                 ram_rdata_i
);

  localparam int unsigned IdxW  = AddrWidth - 2;
  localparam int unsigned RamAw = $clog2(MemDepth);

  logic            instr_gnt;
  logic            data_gnt;
  logic [IdxW-1:0] instr_idx;
  logic [IdxW-1:0] data_idx;
  logic            instr_in_range;
  logic            data_in_range;
  logic [31:0]     rsp_rdata;
  rsp_t            rsp_d;
  rsp_t            rsp_q;
  logic            unused_byte_offs;

  mem_arb_sel #(
    .StarveLimit (StarveLimit)
  ) u_sel (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .instr_gnt_c (instr_gnt),
    .data_gnt_c  (data_gnt)
  );

  // Word-aligned accesses: byte offset bits are ignored.
  assign unused_byte_offs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // Word index decode and range check.
  always_comb begin
    instr_idx      = instr_addr_i[AddrWidth-1:2];
    data_idx       = data_addr_i[AddrWidth-1:2];
    instr_in_range = 64'(instr_idx) < 64'(MemDepth);
    data_in_range  = 64'(data_idx) < 64'(MemDepth);
  end

  // RAM command mux; out-of-range grants never touch the RAM.
  always_comb begin
    instr_gnt_o = instr_gnt;
    data_gnt_o  = data_gnt;
    ram_req_o   = (instr_gnt && instr_in_range) || (data_gnt && data_in_range);
    ram_we_o    = data_gnt && data_we_i;
    ram_be_o    = instr_gnt ? 4'hF : data_be_i;
    ram_addr_o  = instr_gnt ? RamAw'(instr_idx) : RamAw'(data_idx);
    ram_wdata_o = data_wdata_i;
  end

  // Response bookkeeping for the cycle after a grant.
  always_comb begin
    rsp_d = '{owner: OWNER_NONE, err: 1'b0, we: 1'b0};
    if (instr_gnt) begin
      rsp_d.owner = OWNER_INSTR;
      rsp_d.err   = !instr_in_range;
    end else if (data_gnt) begin
      rsp_d.owner = OWNER_DATA;
      rsp_d.err   = !data_in_range;
      rsp_d.we    = data_we_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rsp_q <= '{owner: OWNER_NONE, err: 1'b0, we: 1'b0};
    end else begin
      rsp_q <= rsp_d;
    end
  end

  // Response routing: only the owner sees data; errors and writes return 0.
  always_comb begin
    rsp_rdata      = (rsp_q.err || rsp_q.we) ? 32'h0 : ram_rdata_i;
    instr_rvalid_o = (rsp_q.owner == OWNER_INSTR);
    data_rvalid_o  = (rsp_q.owner == OWNER_DATA);
    instr_err_o    = instr_rvalid_o && rsp_q.err;
    data_err_o     = data_rvalid_o && rsp_q.err;
    instr_rdata_o  = instr_rvalid_o ? rsp_rdata : 32'h0;
    data_rdata_o   = data_rvalid_o ? rsp_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 16384;
  localparam int unsigned RAW   = 14;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic            instr_req_i;
  logic [AW-1:0]   instr_addr_i;
  logic            instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0]     instr_rdata_o;
  logic            data_req_i, data_we_i;
  logic [3:0]      data_be_i;
  logic [AW-1:0]   data_addr_i;
  logic [31:0]     data_wdata_i;
  logic            data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0]     data_rdata_o;
  logic            ram_req_o, ram_we_o;
  logic [3:0]      ram_be_o;
  logic [RAW-1:0]  ram_addr_o;
  logic [31:0]     ram_wdata_o;
  logic [31:0]     ram_rdata_i;

  logic [31:0]     mem [DEPTH];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AddrWidth   (AW),
    .MemDepth    (DEPTH),
    .StarveLimit (4)
  ) dut (
    .clk_i          (clk),
    .rstn_i         (rstn_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_err_o    (instr_err_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_err_o     (data_err_o),
    .data_rdata_o   (data_rdata_o),
    .ram_req_o      (ram_req_o),
    .ram_we_o       (ram_we_o),
    .ram_be_o       (ram_be_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  // Single-port RAM model: read data appears the cycle after a read request.
  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end else begin
        ram_rdata_i <= mem[ram_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [AW-1:0] iaddr,
                       input logic dreq, input logic dwe, input logic [3:0] dbe,
                       input logic [AW-1:0] daddr, input logic [31:0] dwdata);
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    data_req_i   = dreq;
    data_we_i    = dwe;
    data_be_i    = dbe;
    data_addr_i  = daddr;
    data_wdata_i = dwdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ignt"}, 32'(instr_gnt_o), 32'h0);
    check({tag, "_dgnt"}, 32'(data_gnt_o), 32'h0);
    check({tag, "_ramreq"}, 32'(ram_req_o), 32'h0);
    check({tag, "_irv"}, 32'(instr_rvalid_o), 32'h0);
    check({tag, "_drv"}, 32'(data_rvalid_o), 32'h0);
    check({tag, "_ierr"}, 32'(instr_err_o), 32'h0);
    check({tag, "_derr"}, 32'(data_err_o), 32'h0);
    check({tag, "_irdata"}, instr_rdata_o, 32'h0);
    check({tag, "_drdata"}, data_rdata_o, 32'h0);
  endtask

  initial begin
    logic exp_instr;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
    mem[32]     <= 32'h0000_0013;
    ram_rdata_i <= 32'h0;

    // Reset with both ports requesting: everything reads 0.
    rstn_i = 1'b0;
    drive(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    #2;
    check_all_zero("rst");
    tick();
    tick();
    check_all_zero("rst_held");

    // Release mid-cycle; instruction fetch granted in the first cycle.
    rstn_i = 1'b1;
    drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("ifetch_gnt", 32'(instr_gnt_o), 32'h1);
    check("ifetch_dgnt", 32'(data_gnt_o), 32'h0);
    check("ifetch_ramreq", 32'(ram_req_o), 32'h1);
    check("ifetch_addr", 32'(ram_addr_o), 32'd32);
    check("ifetch_we", 32'(ram_we_o), 32'h0);
    check("ifetch_be", 32'(ram_be_o), 32'hF);
    tick();
    check("ifetch_rv", 32'(instr_rvalid_o), 32'h1);
    check("ifetch_rdata", instr_rdata_o, 32'h0000_0013);
    check("ifetch_err", 32'(instr_err_o), 32'h0);
    check("ifetch_drv", 32'(data_rvalid_o), 32'h0);

    // Full-word store at 0x1000.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h1234_5678);
    #1;
    check("st_gnt", 32'(data_gnt_o), 32'h1);
    check("st_igrant", 32'(instr_gnt_o), 32'h0);
    check("st_addr", 32'(ram_addr_o), 32'd1024);
    check("st_we", 32'(ram_we_o), 32'h1);
    check("st_wdata", ram_wdata_o, 32'h1234_5678);
    tick();
    check("st_rv", 32'(data_rvalid_o), 32'h1);
    check("st_rdata", data_rdata_o, 32'h0);
    check("st_irv", 32'(instr_rvalid_o), 32'h0);

    // Load back the same word.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    #1;
    check("ld_gnt", 32'(data_gnt_o), 32'h1);
    check("ld_addr", 32'(ram_addr_o), 32'd1024);
    check("ld_we", 32'(ram_we_o), 32'h0);
    tick();
    check("ld_rv", 32'(data_rvalid_o), 32'h1);
    check("ld_rdata", data_rdata_o, 32'h1234_5678);
    check("ld_err", 32'(data_err_o), 32'h0);

    // Partial store (low half) at 0x1004, then load.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h1004, 32'hAABB_CCDD);
    #1;
    check("pst_be", 32'(ram_be_o), 32'h3);
    check("pst_addr", 32'(ram_addr_o), 32'd1025);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1004, 32'h0);
    tick();
    check("pld_rdata", data_rdata_o, 32'h0000_CCDD);

    // Out-of-range load: word index == depth.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1_0000, 32'h0);
    #1;
    check("oor_gnt", 32'(data_gnt_o), 32'h1);
    check("oor_ramreq", 32'(ram_req_o), 32'h0);
    tick();
    check("oor_rv", 32'(data_rvalid_o), 32'h1);
    check("oor_err", 32'(data_err_o), 32'h1);
    check("oor_rdata", data_rdata_o, 32'h0);
    check("oor_irv", 32'(instr_rvalid_o), 32'h0);

    // One lone fetch so the last grant is the instruction port.
    drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("lone_rv", 32'(instr_rvalid_o), 32'h1);
    check("lone_err", 32'(instr_err_o), 32'h0);

    // Continuous contention.
    drive(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARBITER_RR_EN
      exp_instr = (i % 2) == 1;
`else
      exp_instr = (i % 5) == 4;
`endif
      #1;
      check($sformatf("cont%0d_igrant", i), 32'(instr_gnt_o), 32'(exp_instr));
      check($sformatf("cont%0d_dgnt", i), 32'(data_gnt_o), 32'(!exp_instr));
      check($sformatf("cont%0d_both", i), 32'(instr_gnt_o && data_gnt_o), 32'h0);
      tick();
      if (exp_instr) begin
        check($sformatf("cont%0d_irdata", i), instr_rdata_o, 32'h0000_0013);
        check($sformatf("cont%0d_drv", i), 32'(data_rvalid_o), 32'h0);
      end else begin
        check($sformatf("cont%0d_drdata", i), data_rdata_o, 32'h1234_5678);
        check($sformatf("cont%0d_irv", i), 32'(instr_rvalid_o), 32'h0);
      end
    end

    // Reset asserted right after a granted load: no response, all zero.
    drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    #1;
    check("prerst_gnt", 32'(data_gnt_o), 32'h1);
    @(posedge clk);
    rstn_i = 1'b0;
    drive(1'b1, 32'h80, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
    #1;
    check_all_zero("midrst");
    tick();
    check_all_zero("midrst_held");

    // Release: normal grant in the first cycle.
    rstn_i = 1'b1;
    drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    check("post_igrant", 32'(instr_gnt_o), 32'h1);
    check("post_drv", 32'(data_rvalid_o), 32'h0);
    check("post_irv", 32'(instr_rvalid_o), 32'h0);
    tick();
    check("post_rv", 32'(instr_rvalid_o), 32'h1);
    check("post_rdata", instr_rdata_o, 32'h0000_0013);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
